sort_seq_ctrl: RTL and testbench

//  Streaming front/back end for the min-sort datapath. Collects a frame of up to M words on a

---
 rtl/sort_pkg.sv | 16 +
 rtl/sort_stage.sv | 35 +++
 rtl/sort_seq_ctrl.sv | 98 +++++++++
 tb/tb_sort_seq_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared parameters and types for the min-sort datapath and its streaming controller.
package sort_pkg;

    localparam int M     = 8;
    localparam int N     = 16;
    localparam int W     = $clog2(N);
    localparam int CNT_W = $clog2(M + 1);

    typedef logic [M-1:0][N-1:0] chi_t;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/sort_stage.sv
// One combinational min-sort step: reports the smallest row of chi and returns chi with
// that row retired to all-ones. Ties resolve to the lowest row, so duplicates leave one at a time.
module sort_stage
    import sort_pkg::*;
(
    input  chi_t           i_chi,
    output logic [N-1:0]   o_y_q,
    output chi_t           o_chi
);

    logic [N-1:0] w_min;
    logic [W-1:0] w_idx;

    always_comb begin
        w_min = i_chi[0];
        w_idx = '0;
        for (int i = 1; i < M; i++) begin
            if (i_chi[i] < w_min) begin
                w_min = i_chi[i];
                w_idx = W'(i);
            end
        end
    end

    always_comb begin
        o_y_q = w_min;
        o_chi = i_chi;
        for (int i = 0; i < M; i++) begin
            if (w_idx == W'(i)) begin
                o_chi[i] = '1;
            end
        end
    end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Streaming load/emit controller around sort_stage: collects a frame, then emits it sorted.
// Build option SORT_SEQ_DESC_EN: invert data on load and emit for descending output.
module sort_seq_ctrl
    import sort_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [N-1:0] i_data,
    input  logic         i_last,
    output logic         o_ready,
    output logic         o_valid,
    output logic [N-1:0] o_data,
    output logic         o_last,
    input  logic         i_ready
);

    // Handshakes: a word moves on a rising edge where valid and ready are both high;
    // valid never depends on ready, and held output data is stable until accepted.

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_emit_cnt;
    logic [CNT_W-1:0] r_frame_cnt;
    chi_t             r_chi;

    logic [N-1:0]     w_y;
    chi_t             w_chi_next;
    logic [N-1:0]     w_din;
    logic [N-1:0]     w_dout;
    logic             w_last;
    logic             w_close;

    sort_stage u_sort_stage (
        .i_chi (r_chi),
        .o_y_q (w_y),
        .o_chi (w_chi_next)
    );

`ifdef SORT_SEQ_DESC_EN
    // Inverting both ways turns the min-first stage into a max-first one; padding stays '1.
    assign w_din  = ~i_data;
    assign w_dout = ~w_y;
`else
    assign w_din  = i_data;
    assign w_dout = w_y;
`endif

    assign w_last  = (r_state == S_EMIT) && (r_emit_cnt == (r_frame_cnt - CNT_W'(1)));
    assign w_close = i_last || (r_load_cnt == CNT_W'(M - 1));

    assign o_ready = (r_state == S_LOAD) && i_rst_n;
    assign o_valid = (r_state == S_EMIT);
    assign o_data  = (r_state == S_EMIT) ? w_dout : '0;
    assign o_last  = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_LOAD;
            r_load_cnt  <= '0;
            r_emit_cnt  <= '0;
            r_frame_cnt <= '0;
            r_chi       <= '1;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (i_valid) begin
                        for (int i = 0; i < M; i++) begin
                            if (r_load_cnt == CNT_W'(i)) begin
                                r_chi[i] <= w_din;
                            end
                        end
                        r_load_cnt <= r_load_cnt + CNT_W'(1);
                        if (w_close) begin
                            r_frame_cnt <= r_load_cnt + CNT_W'(1);
                            r_state     <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_ready) begin
                        if (w_last) begin
                            r_chi       <= '1;
                            r_load_cnt  <= '0;
                            r_emit_cnt  <= '0;
                            r_state     <= S_LOAD;
                        end else begin
                            r_chi      <= w_chi_next;
                            r_emit_cnt <= r_emit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl: table of frames with hand-sorted results plus reset corner.
module tb_sort_seq_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_last;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_last;
    logic        i_ready;

    int checks = 0;
    int errors = 0;

`ifdef SORT_SEQ_DESC_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    typedef struct {
        int          n;
        bit          stall;
        logic [15:0] din[8];
        logic [15:0] dout[8];
    } vec_t;

    vec_t tbl[6];

    sort_seq_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            int b;
            @(negedge clk);
            b = 0;
            while (!o_ready && b < 20) begin
                @(negedge clk);
                b++;
            end
            chk("load_ready", o_ready, 1);
            i_valid = 1'b1;
            i_data  = v.din[i];
            i_last  = (i == v.n - 1);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
        chk("first_valid_latency", o_valid, 1);
        chk("ready_low_in_emit", o_ready, 0);
    endtask

    // Collects up to stop_after words; every cycle, stalled or not, the held word is checked.
    task automatic recv_frame(input vec_t v, input int stop_after);
        int k;
        int cyc;
        logic [15:0] e;
        k   = 0;
        cyc = 0;
        while (k < v.n && k < stop_after && cyc < 200) begin
            e = DESC ? v.dout[v.n - 1 - k] : v.dout[k];
            i_ready = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            chk("emit_valid", o_valid, 1);
            chk("emit_data", o_data, e);
            chk("emit_last", o_last, (k == v.n - 1));
            @(negedge clk);
            if (i_ready) k++;
            cyc++;
        end
        i_ready = 1'b0;
        chk("emit_count", k, (stop_after < v.n) ? stop_after : v.n);
    endtask

    initial begin
        vec_t r1;
        vec_t r2;

        tbl[0] = '{n: 8, stall: 0, din: '{5, 3, 9, 1, 7, 2, 8, 4},
                   dout: '{1, 2, 3, 4, 5, 7, 8, 9}};
        tbl[1] = '{n: 3, stall: 0, din: '{12, 6, 16'h0010, 0, 0, 0, 0, 0},
                   dout: '{6, 12, 16, 0, 0, 0, 0, 0}};
        tbl[2] = '{n: 4, stall: 0, din: '{4, 4, 1, 4, 0, 0, 0, 0},
                   dout: '{1, 4, 4, 4, 0, 0, 0, 0}};
        tbl[3] = '{n: 3, stall: 0, din: '{7, 16'hFFFF, 3, 0, 0, 0, 0, 0},
                   dout: '{3, 7, 16'hFFFF, 0, 0, 0, 0, 0}};
        tbl[4] = '{n: 8, stall: 1, din: '{10, 200, 3, 3000, 45, 6, 70, 1},
                   dout: '{1, 3, 6, 10, 45, 70, 200, 3000}};
        tbl[5] = '{n: 3, stall: 0, din: '{5, 3, 9, 0, 0, 0, 0, 0},
                   dout: '{3, 5, 9, 0, 0, 0, 0, 0}};
        r1 = '{n: 4, stall: 0, din: '{8, 6, 7, 2, 0, 0, 0, 0},
               dout: '{2, 6, 7, 8, 0, 0, 0, 0}};
        r2 = '{n: 2, stall: 0, din: '{3, 1, 0, 0, 0, 0, 0, 0},
               dout: '{1, 3, 0, 0, 0, 0, 0, 0}};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_data", o_data, 0);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_valid", o_valid, 0);

        for (int t = 0; t < 6; t++) begin
            send_frame(tbl[t]);
            recv_frame(tbl[t], 8);
            chk("turnaround_valid", o_valid, 0);
            chk("turnaround_ready", o_ready, 1);
        end

        // Reset lands mid-emit after two words have left; nothing of that frame may follow.
        send_frame(r1);
        recv_frame(r1, 2);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 0);
        chk("midrst_last", o_last, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", o_ready, 1);
        chk("midrst_release_valid", o_valid, 0);
        send_frame(r2);
        recv_frame(r2, 8);
        chk("after_rst_frame_valid", o_valid, 0);
        repeat (2) @(negedge clk);
        chk("idle_valid", o_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
